// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Imported by uart_rx and its far-end partner uart_tx.
//   uart_state_t    : receive/transmit frame phase
//   UART_DATA_BITS  : payload bits per frame (8N1)
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser for asynchronous inputs
// Ports:
//   clkIn    in  1      destination clock
//   rstIn    in  1      asynchronous active-high reset (both flops load RESET_VALUE)
//   asyncIn  in  WIDTH  asynchronous input
//   syncOut  out WIDTH  input re-timed into clkIn (second flop)
`timescale 1ns/1ps
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut
);

    logic [WIDTH-1:0] metaReg;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            metaReg <= RESET_VALUE;
            syncOut <= RESET_VALUE;
        end else begin
            metaReg <= asyncIn;
            syncOut <= metaReg;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, mid-bit sampling
// Ports:
//   clkIn        in  1  clock
//   rstIn        in  1  asynchronous active-high reset
//   rxIn         in  1  serial line, asynchronous, idle high
//   dataOut      out 8  last correctly framed byte, held until the next good byte
//   validOut     out 1  one-cycle strobe: dataOut just updated
//   frameErrOut  out 1  one-cycle strobe: stop bit sampled low, byte discarded
//   busyOut      out 1  high from start detection until the stop bit is sampled
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALER_COUNT = 234
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic                      rxIn,
    output logic [UART_DATA_BITS-1:0] dataOut,
    output logic                      validOut,
    output logic                      frameErrOut,
    output logic                      busyOut
);

    localparam int BIT_CYCLES = PRESCALER_COUNT + 1;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int PRES_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [PRES_W-1:0] PRES_LAST     = PRES_W'(BIT_CYCLES - 1);
    localparam logic [PRES_W-1:0] PRES_HALF     = PRES_W'(HALF - 1);
    localparam logic [3:0]        BITS_LAST     = 4'(UART_DATA_BITS - 1);
    localparam logic [3:0]        BITS_SATURATE = 4'(UART_DATA_BITS);

    logic rxSync;

    uart_state_t               state, stateNext;
    logic [PRES_W-1:0]         prescaler, prescalerNext;
    logic [3:0]                bitCount, bitCountNext;
    logic [UART_DATA_BITS-1:0] shiftReg, shiftRegNext;
    logic [UART_DATA_BITS-1:0] dataNext;
    logic                      armed, armedNext;
    logic                      validNext, frameErrNext, busyNext;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rxSync (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .asyncIn (rxIn),
        .syncOut (rxSync)
    );

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state       <= IDLE;
            prescaler   <= '0;
            bitCount    <= '0;
            shiftReg    <= '0;
            armed       <= 1'b0;
            dataOut     <= '0;
            validOut    <= 1'b0;
            frameErrOut <= 1'b0;
            busyOut     <= 1'b0;
        end else begin
            state       <= stateNext;
            prescaler   <= prescalerNext;
            bitCount    <= bitCountNext;
            shiftReg    <= shiftRegNext;
            armed       <= armedNext;
            dataOut     <= dataNext;
            validOut    <= validNext;
            frameErrOut <= frameErrNext;
            busyOut     <= busyNext;
        end
    end

    always_comb begin
        stateNext     = state;
        prescalerNext = prescaler;
        bitCountNext  = bitCount;
        shiftRegNext  = shiftReg;
        armedNext     = armed;
        dataNext      = dataOut;
        validNext     = 1'b0;
        frameErrNext  = 1'b0;

        case (state)
            IDLE: begin
                prescalerNext = '0;
                // Break protection: a start edge only counts once the line
                // has been seen idle-high since reset or the last framing error.
                if (rxSync) begin
                    armedNext = 1'b1;
                end else if (armed) begin
                    stateNext = START_BIT;
                end
            end

            START_BIT: begin
                if (prescaler == PRES_HALF) begin
                    prescalerNext = '0;
                    if (!rxSync) begin
                        stateNext    = DATA;
                        bitCountNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    prescalerNext = prescaler + 1'b1;
                end
            end

            DATA: begin
                if (prescaler == PRES_LAST) begin
                    prescalerNext = '0;
                    shiftRegNext  = {rxSync, shiftReg[UART_DATA_BITS-1:1]};
                    bitCountNext  = (bitCount >= BITS_SATURATE) ? BITS_SATURATE
                                                                : bitCount + 1'b1;
                    if (bitCount >= BITS_LAST) begin
                        stateNext = STOP_BIT;
                    end
                end else begin
                    prescalerNext = prescaler + 1'b1;
                end
            end

            STOP_BIT: begin
                if (prescaler == PRES_LAST) begin
                    prescalerNext = '0;
                    stateNext     = IDLE;
                    if (rxSync) begin
                        dataNext  = shiftReg;
                        validNext = 1'b1;
                    end else begin
                        frameErrNext = 1'b1;
                        armedNext    = 1'b0;
                    end
                end else begin
                    prescalerNext = prescaler + 1'b1;
                end
            end

            default: begin
                stateNext     = IDLE;
                prescalerNext = '0;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int      PRESC  = 15;
    localparam int      BITC   = PRESC + 1;
    localparam int      HALFC  = BITC / 2;
    localparam realtime TCLK   = 10.0;
    localparam realtime TBIT   = TCLK * BITC;
    localparam realtime TFAST  = TBIT * 0.98;
    localparam realtime TSLOW  = TBIT * 1.02;
    localparam int      LAT    = 2 + HALFC + 9 * BITC;

    logic       clkIn = 1'b0;
    logic       rstIn = 1'b1;
    logic       rxIn  = 1'b1;
    logic [7:0] dataOut;
    logic       validOut;
    logic       frameErrOut;
    logic       busyOut;

    uart_rx #(.PRESCALER_COUNT(PRESC)) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .rxIn        (rxIn),
        .dataOut     (dataOut),
        .validOut    (validOut),
        .frameErrOut (frameErrOut),
        .busyOut     (busyOut)
    );

    always #(TCLK / 2) clkIn = ~clkIn;

    int         passCnt = 0;
    int         totalCnt = 0;
    logic [7:0] expQ[$];
    int         errExpected = 0;
    int         cycleCnt = 0;
    int         fallCycle = 0;
    int         lastValidCycle = 0;
    int         validCnt = 0;
    int         errCnt = 0;
    int         busyRises = 0;
    int         busyFalls = 0;
    logic       busyPrev = 1'b0;

    always @(posedge clkIn) cycleCnt++;

    task automatic check(input string name, input int actual, input int expected);
        totalCnt++;
        if (actual == expected) passCnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        totalCnt++;
        if (actual >= lo && actual <= hi) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    endtask

    // Monitor: pops the scoreboard whenever the receiver strobes.
    always @(negedge clkIn) begin
        if (!rstIn) begin
            if (validOut || frameErrOut)
                check("strobe_exclusive", int'(validOut & frameErrOut), 0);
            if (validOut) begin
                validCnt++;
                lastValidCycle = cycleCnt;
                if (expQ.size() == 0) check("valid_with_pending_byte", expQ.size(), 1);
                else                  check("rx_byte", dataOut, expQ.pop_front());
            end
            if (frameErrOut) begin
                errCnt++;
                check("frame_err_expected", int'(errExpected > 0), 1);
                if (errExpected > 0) errExpected--;
            end
        end
        if (busyOut && !busyPrev) busyRises++;
        if (!busyOut && busyPrev) busyFalls++;
        busyPrev = busyOut;
    end

    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input realtime bitTime);
        fallCycle = cycleCnt;
        rxIn = 1'b0;
        #(bitTime);
        for (int i = 0; i < 8; i++) begin
            rxIn = b[i];
            #(bitTime);
        end
        rxIn = stopBit;
        #(bitTime);
    endtask

    initial begin
        #(2ms);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0;
        int r0;
        int busyHigh;
        realtime bt;

        rxIn  = 1'b1;
        rstIn = 1'b1;
        repeat (3) @(negedge clkIn);
        check("reset_dataOut", dataOut, 0);
        check("reset_validOut", validOut, 0);
        check("reset_frameErrOut", frameErrOut, 0);
        check("reset_busyOut", busyOut, 0);
        rstIn = 1'b0;
        repeat (5) @(negedge clkIn);

        // 1: single frame, latency
        expQ.push_back(8'hA5);
        sendFrame(8'hA5, 1'b1, TBIT);
        repeat (BITC) @(negedge clkIn);
        check("t1_valid_count", validCnt, 1);
        check("t1_dataOut", dataOut, 8'hA5);
        check("t1_frame_err_count", errCnt, 0);
        checkRange("t1_latency", lastValidCycle - fallCycle, LAT - 1, LAT + 1);

        // 2: back-to-back frames
        f0 = busyFalls;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h5A);
        @(negedge clkIn);
        sendFrame(8'h00, 1'b1, TBIT);
        sendFrame(8'hFF, 1'b1, TBIT);
        sendFrame(8'h5A, 1'b1, TBIT);
        repeat (BITC) @(negedge clkIn);
        check("t2_valid_count", validCnt, 4);
        check("t2_busy_falls", busyFalls - f0, 3);
        check("t2_queue_drained", expQ.size(), 0);

        // 3: short glitch on the line
        r0 = busyRises;
        @(negedge clkIn);
        rxIn = 1'b0;
        repeat (5) @(negedge clkIn);
        rxIn = 1'b1;
        repeat (3 * BITC) @(negedge clkIn);
        check("t3_busy_pulses", busyRises - r0, 1);
        check("t3_busy_idle", busyOut, 0);
        check("t3_valid_count", validCnt, 4);
        check("t3_frame_err_count", errCnt, 0);

        // 4: stop bit low, then line held low
        errExpected++;
        @(negedge clkIn);
        sendFrame(8'h3C, 1'b0, TBIT);
        repeat (2) @(negedge clkIn);
        check("t4_frame_err_count", errCnt, 1);
        check("t4_dataOut_held", dataOut, 8'h5A);
        busyHigh = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkIn);
            if (busyOut) busyHigh++;
        end
        check("t4_break_no_start", busyHigh, 0);
        check("t4_valid_count", validCnt, 4);
        rxIn = 1'b1;
        repeat (2 * BITC) @(negedge clkIn);

        // 5: reset during DATA
        @(negedge clkIn);
        rxIn = 1'b0;
        #(TBIT);
        rxIn = 1'b1;
        #(3 * TBIT);
        check("t5_busy_in_data", busyOut, 1);
        #2;
        rstIn = 1'b1;
        #1;
        check("t5_rst_dataOut", dataOut, 0);
        check("t5_rst_validOut", validOut, 0);
        check("t5_rst_frameErrOut", frameErrOut, 0);
        check("t5_rst_busyOut", busyOut, 0);
        repeat (3) @(negedge clkIn);
        rstIn = 1'b0;
        repeat (2 * BITC) @(negedge clkIn);
        expQ.push_back(8'h81);
        sendFrame(8'h81, 1'b1, TBIT);
        repeat (BITC) @(negedge clkIn);
        check("t5_valid_count", validCnt, 5);
        check("t5_dataOut", dataOut, 8'h81);

        // 6: all byte values at +/-2% bit-period skew
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       bt = TFAST;
                1:       bt = TSLOW;
                default: bt = TBIT;
            endcase
            expQ.push_back(8'(i * 37 + 11));
            sendFrame(8'(i * 37 + 11), 1'b1, bt);
        end
        repeat (2 * BITC) @(negedge clkIn);
        check("t6_valid_count", validCnt, 5 + 256);
        check("t6_frame_err_count", errCnt, 1);
        check("t6_queue_drained", expQ.size(), 0);
        check("t6_err_expected_drained", errExpected, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
